// File: rtl/fpu_uart_pkg.sv
// Shared encodings and constants for the FPU UART operand loader.
// Both the byte receiver and the packet assembler import this package.
package fpu_uart_pkg;

  localparam int MIN_CPB        = 4;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_OPS,
    P_HOLD
  } pkt_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser on rx_i, then a sampling FSM that
// centres each bit sample cpb cycles apart starting at mid-start-bit.
module uart_rx_byte
  import fpu_uart_pkg::*;
#(
  parameter int CPB_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  input  logic [CPB_WIDTH-1:0] clks_per_bit,
  output logic [7:0]           byte_o,
  output logic                 byte_done_o,
  output logic                 frame_err_o,
  output logic                 start_o,
  output logic [CPB_WIDTH-1:0] cpb_o,
  output rx_state_e            state_o
);

  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e            state_q;
  logic [CPB_WIDTH-1:0] cpb_q, cnt_q, cpb_clamped;
  logic [2:0]           bit_q;
  logic [7:0]           shift_q;
  logic                 stop_err_q, frame_err_q;
  logic                 bit_tick;

  assign cpb_clamped = (clks_per_bit < CPB_WIDTH'(MIN_CPB)) ? CPB_WIDTH'(MIN_CPB) : clks_per_bit;
  assign start_o     = (state_q == R_IDLE) && rx_prev_q && !rx_sync_q;
  assign bit_tick    = (cnt_q == cpb_q);

  // Decoded in the stop-sample cycle so the packet FSM can react one clock later.
  assign byte_done_o = (state_q == R_STOP) && !stop_err_q && bit_tick && rx_sync_q;
  assign byte_o      = shift_q;
  assign frame_err_o = frame_err_q;
  assign cpb_o       = cpb_q;
  assign state_o     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= R_IDLE;
      cpb_q       <= CPB_WIDTH'(MIN_CPB);
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      stop_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      frame_err_q <= 1'b0;
      case (state_q)
        R_IDLE: begin
          if (start_o) begin
            cpb_q   <= cpb_clamped;
            cnt_q   <= CPB_WIDTH'(1);
            state_q <= R_START;
          end
        end
        R_START: begin
          if (cnt_q == (cpb_q >> 1)) begin
            cnt_q <= CPB_WIDTH'(1);
            if (!rx_sync_q) begin
              bit_q   <= '0;
              state_q <= R_DATA;
            end else begin
              state_q <= R_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CPB_WIDTH'(1);
          end
        end
        R_DATA: begin
          if (bit_tick) begin
            cnt_q   <= CPB_WIDTH'(1);
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'(UART_DATA_BITS - 1)) state_q <= R_STOP;
          end else begin
            cnt_q <= cnt_q + CPB_WIDTH'(1);
          end
        end
        R_STOP: begin
          // After a framing error, hold here until the line returns high.
          if (stop_err_q) begin
            if (rx_sync_q) begin
              stop_err_q <= 1'b0;
              state_q    <= R_IDLE;
            end
          end else if (bit_tick) begin
            if (rx_sync_q) begin
              state_q <= R_IDLE;
            end else begin
              stop_err_q  <= 1'b1;
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CPB_WIDTH'(1);
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_operand_loader.sv
// UART packet receiver: assembles {opcode, NUM_OPS operands} from received
// bytes and presents them on a valid/ready interface with error pulses.
module uart_operand_loader
  import fpu_uart_pkg::*;
#(
  parameter int OP_WIDTH     = 16,
  parameter int NUM_OPS      = 3,
  parameter int CPB_WIDTH    = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_i,
  input  logic [CPB_WIDTH-1:0]         clks_per_bit,
  output logic                         pkt_valid_o,
  input  logic                         pkt_ready_i,
  output logic [7:0]                   opcode_o,
  output logic [NUM_OPS*OP_WIDTH-1:0]  operands_o,
  output logic                         frame_err_o,
  output logic                         timeout_o,
  output logic                         overrun_o,
  output logic                         busy_o
);

  // Handshake: the packet is transferred on any clock edge where
  // pkt_valid_o && pkt_ready_i; outputs are frozen while valid is high.

  localparam int NBYTES = 1 + NUM_OPS * OP_WIDTH / 8;
  localparam int OPB    = NBYTES - 1;
  localparam int IDX_W  = (OPB > 1) ? $clog2(OPB) : 1;
  localparam int TO_W   = CPB_WIDTH + $clog2(TIMEOUT_BITS) + 1;

  logic [7:0]           rx_byte;
  logic                 rx_byte_done, rx_frame_err, rx_start;
  logic [CPB_WIDTH-1:0] rx_cpb;
  rx_state_e            rx_state;

  pkt_state_e                  pkt_state_q;
  logic [IDX_W-1:0]            idx_q;
  logic [7:0]                  opcode_q;
  logic [NUM_OPS*OP_WIDTH-1:0] ops_q;
  logic [TO_W-1:0]             to_cnt_q, to_limit;
  logic                        timeout_q, overrun_q;

  uart_rx_byte #(.CPB_WIDTH(CPB_WIDTH)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx_i),
    .clks_per_bit (clks_per_bit),
    .byte_o       (rx_byte),
    .byte_done_o  (rx_byte_done),
    .frame_err_o  (rx_frame_err),
    .start_o      (rx_start),
    .cpb_o        (rx_cpb),
    .state_o      (rx_state)
  );

  assign to_limit    = TO_W'(TIMEOUT_BITS) * TO_W'(rx_cpb);
  assign pkt_valid_o = (pkt_state_q == P_HOLD);
  assign busy_o      = (pkt_state_q == P_OPS);
  assign opcode_o    = opcode_q;
  assign operands_o  = ops_q;
  assign frame_err_o = rx_frame_err;
  assign timeout_o   = timeout_q;
  assign overrun_o   = overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_state_q <= P_IDLE;
      idx_q       <= '0;
      opcode_q    <= '0;
      ops_q       <= '0;
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;

      // Saturating inter-byte timer, live only while a packet is partial.
      if (pkt_state_q != P_OPS || rx_byte_done || rx_start) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q < to_limit) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end

      case (pkt_state_q)
        P_IDLE: begin
          if (rx_byte_done) begin
            opcode_q    <= rx_byte;
            ops_q       <= '0;
            idx_q       <= '0;
            pkt_state_q <= P_OPS;
          end
        end
        P_OPS: begin
          if (rx_frame_err) begin
            opcode_q    <= '0;
            ops_q       <= '0;
            pkt_state_q <= P_IDLE;
          end else if (rx_byte_done) begin
            for (int k = 0; k < OPB; k++) begin
              if (idx_q == IDX_W'(k)) ops_q[k*8 +: 8] <= rx_byte;
            end
            if (idx_q == IDX_W'(OPB - 1)) pkt_state_q <= P_HOLD;
            else                          idx_q       <= idx_q + IDX_W'(1);
          end else if (to_cnt_q >= to_limit && rx_state == R_IDLE) begin
            timeout_q   <= 1'b1;
            opcode_q    <= '0;
            ops_q       <= '0;
            pkt_state_q <= P_IDLE;
          end
        end
        P_HOLD: begin
          if (pkt_ready_i) begin
            // A byte landing on the handshake cycle starts the next packet.
            if (rx_byte_done) begin
              opcode_q    <= rx_byte;
              ops_q       <= '0;
              idx_q       <= '0;
              pkt_state_q <= P_OPS;
            end else begin
              pkt_state_q <= P_IDLE;
            end
          end else if (rx_byte_done) begin
            overrun_q <= 1'b1;
          end
        end
        default: pkt_state_q <= P_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_operand_loader.sv
// Directed bench for uart_operand_loader: default config (A) and a
// 32-bit x 2-operand config (B), with hand-computed expected packets.
module tb_uart_operand_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_a = 1'b1;
  logic        rx_b = 1'b1;
  logic [15:0] cpb = 16'd4;
  logic        ready_a = 1'b1;
  logic        ready_b = 1'b1;
  int          bit_clks = 4;

  logic        pv_a, fe_a_o, to_a_o, ovr_a_o, busy_a;
  logic [7:0]  opc_a;
  logic [47:0] ops_a;
  logic        pv_b, fe_b_o, to_b_o, ovr_b_o, busy_b;
  logic [7:0]  opc_b;
  logic [63:0] ops_b;

  int errors = 0;
  int checks = 0;
  int hs_a = 0, hs_b = 0, fe_a = 0, to_a = 0, ovr_a = 0;
  logic [7:0]  last_opc_a, last_opc_b;
  logic [47:0] last_ops_a;
  logic [63:0] last_ops_b;

  uart_operand_loader dut_a (
    .clk(clk), .rst(rst), .rx_i(rx_a), .clks_per_bit(cpb),
    .pkt_valid_o(pv_a), .pkt_ready_i(ready_a), .opcode_o(opc_a), .operands_o(ops_a),
    .frame_err_o(fe_a_o), .timeout_o(to_a_o), .overrun_o(ovr_a_o), .busy_o(busy_a)
  );

  uart_operand_loader #(.OP_WIDTH(32), .NUM_OPS(2)) dut_b (
    .clk(clk), .rst(rst), .rx_i(rx_b), .clks_per_bit(cpb),
    .pkt_valid_o(pv_b), .pkt_ready_i(ready_b), .opcode_o(opc_b), .operands_o(ops_b),
    .frame_err_o(fe_b_o), .timeout_o(to_b_o), .overrun_o(ovr_b_o), .busy_o(busy_b)
  );

  // clock
  always #5 clk = ~clk;

  // monitor: counts handshakes and pulses away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (pv_a && ready_a) begin
        hs_a++;
        last_opc_a = opc_a;
        last_ops_a = ops_a;
      end
      if (pv_b && ready_b) begin
        hs_b++;
        last_opc_b = opc_b;
        last_ops_b = ops_b;
      end
      if (fe_a_o)  fe_a++;
      if (to_a_o)  to_a++;
      if (ovr_a_o) ovr_a++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
    repeat (bit_clks) @(posedge clk);
  endtask

  task automatic send_byte(input int which, input logic [7:0] b, input bit good_stop);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, b[i]);
    drive_bit(which, good_stop);
    if (!good_stop) drive_bit(which, 1'b1);
  endtask

  task automatic send_pkt1();
    send_byte(0, 8'h01, 1); send_byte(0, 8'h80, 1); send_byte(0, 8'h3F, 1);
    send_byte(0, 8'h00, 1); send_byte(0, 8'h40, 1); send_byte(0, 8'h00, 1);
    send_byte(0, 8'h00, 1);
  endtask

  task automatic wait_hs(input int which, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (which == 0 && hs_a >= target) break;
      if (which == 1 && hs_b >= target) break;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  localparam logic [47:0] PKT1_OPS = 48'h0000_4000_3F80;

  initial begin
    int base;
    int unstable;
    // reset
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_valid", pv_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_opcode", opc_a, 0);
    check("rst_operands", ops_a, 0);
    rst = 1'b0;
    idle(8);

    // 1: basic packet with ready high
    send_pkt1();
    wait_hs(0, 1, 200);
    check("t1_hs", hs_a, 1);
    check("t1_opcode", last_opc_a, 8'h01);
    check("t1_operands", last_ops_a, PKT1_OPS);
    idle(10);
    @(negedge clk);
    check("t1_single_pulse", hs_a, 1);
    check("t1_valid_low", pv_a, 0);

    // 2: hold with ready low, extra byte overruns
    ready_a = 1'b0;
    ovr_a = 0;
    send_pkt1();
    for (int i = 0; i < 200 && !pv_a; i++) @(negedge clk);
    check("t2_valid", pv_a, 1);
    unstable = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!pv_a || opc_a !== 8'h01 || ops_a !== PKT1_OPS) unstable++;
    end
    check("t2_stable", unstable, 0);
    send_byte(0, 8'h55, 1);
    idle(10);
    @(negedge clk);
    check("t2_overrun", ovr_a, 1);
    check("t2_hold_opcode", opc_a, 8'h01);
    check("t2_hold_operands", ops_a, PKT1_OPS);
    ready_a = 1'b1;
    wait_hs(0, 2, 20);
    check("t2_hs", hs_a, 2);
    check("t2_opcode", last_opc_a, 8'h01);
    check("t2_operands", last_ops_a, PKT1_OPS);
    idle(4);
    @(negedge clk);
    check("t2_busy_after", busy_a, 0);

    // 3: framing error after opcode, then a clean packet
    fe_a = 0;
    send_byte(0, 8'h01, 1);
    send_byte(0, 8'h80, 0);
    idle(8);
    @(negedge clk);
    check("t3_frame_err", fe_a, 1);
    check("t3_busy", busy_a, 0);
    check("t3_valid", pv_a, 0);
    idle(8);
    send_pkt1();
    wait_hs(0, 3, 200);
    check("t3_hs", hs_a, 3);
    check("t3_opcode", last_opc_a, 8'h01);
    check("t3_operands", last_ops_a, PKT1_OPS);

    // 4: partial packet times out after 32*4 idle clocks
    idle(8);
    to_a = 0;
    send_byte(0, 8'h07, 1);
    send_byte(0, 8'h11, 1);
    send_byte(0, 8'h22, 1);
    idle(100);
    @(negedge clk);
    check("t4_no_early_timeout", to_a, 0);
    check("t4_busy_before", busy_a, 1);
    for (int i = 0; i < 100 && to_a == 0; i++) @(negedge clk);
    check("t4_timeout", to_a, 1);
    idle(2);
    @(negedge clk);
    check("t4_busy_after", busy_a, 0);
    check("t4_no_pkt", hs_a, 3);

    // 5: glitch ignored; clks_per_bit=2 clamps to 4
    cpb = 16'd2;
    fe_a = 0;
    rx_a = 1'b0;
    idle(2);
    rx_a = 1'b1;
    idle(30);
    @(negedge clk);
    check("t5_glitch_busy", busy_a, 0);
    check("t5_glitch_fe", fe_a, 0);
    check("t5_glitch_valid", pv_a, 0);
    send_pkt1();
    wait_hs(0, 4, 200);
    check("t5_hs", hs_a, 4);
    check("t5_opcode", last_opc_a, 8'h01);
    check("t5_operands", last_ops_a, PKT1_OPS);

    // 6: reset mid-operand at cpb=348
    cpb = 16'd348;
    bit_clks = 348;
    idle(8);
    send_byte(0, 8'h09, 1);
    send_byte(0, 8'hAA, 1);
    send_byte(0, 8'hBB, 1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    @(negedge clk);
    check("t6_busy_pre", busy_a, 1);
    check("t6_opcode_pre", opc_a, 8'h09);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_busy", busy_a, 0);
    check("t6_rst_opcode", opc_a, 0);
    check("t6_rst_operands", ops_a, 0);
    check("t6_rst_valid", pv_a, 0);
    rx_a = 1'b1;
    rst = 1'b0;
    idle(3 * 348);
    base = hs_a;
    send_pkt1();
    wait_hs(0, base + 1, 2000);
    check("t6_hs", hs_a, base + 1);
    check("t6_opcode", last_opc_a, 8'h01);
    check("t6_operands", last_ops_a, PKT1_OPS);

    // 7: 32-bit x 2 operand configuration
    cpb = 16'd4;
    bit_clks = 4;
    idle(20);
    send_byte(1, 8'h02, 1);
    send_byte(1, 8'h78, 1); send_byte(1, 8'h56, 1); send_byte(1, 8'h34, 1); send_byte(1, 8'h12, 1);
    send_byte(1, 8'hEF, 1); send_byte(1, 8'hCD, 1); send_byte(1, 8'hAB, 1); send_byte(1, 8'h89, 1);
    wait_hs(1, 1, 200);
    check("t7_hs", hs_b, 1);
    check("t7_opcode", last_opc_b, 8'h02);
    check("t7_operands", last_ops_b, 64'h89AB_CDEF_1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
